// File: rtl/stage_e_muldiv_if.sv
// Bundle of the execute-stage multiply/divide signals between the pipeline
// (master) and the muldiv unit (slave).
//
// Handshake: start is a one-cycle valid qualified by md_op. The unit is ready
// exactly when busy == 0; a start seen while busy == 1 is dropped, not queued,
// so the master must only raise start when it has observed busy == 0.
interface stage_e_muldiv_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        rd_hi;
    logic        md_use_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MD_out;

    modport master (
        output start, md_op, A_E, B_E, rd_hi, md_use_D,
        input  busy, md_stall, HI, LO, MD_out
    );

    modport slave (
        input  start, md_op, A_E, B_E, rd_hi, md_use_D,
        output busy, md_stall, HI, LO, MD_out
    );
endinterface

// File: rtl/stage_e_muldiv.sv
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// Results are computed on the accepting edge into pending registers and are
// committed to HI/LO only when the fixed-latency busy counter expires.
module stage_e_muldiv #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    stage_e_muldiv_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;

    logic               mul_signed;
    logic signed [32:0] mul_a, mul_b;
    logic signed [65:0] product;

    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, div_den, q_mag, r_mag, quot, rem;

    // 33-bit operands let one signed multiplier serve both MULT and MULTU.
    always_comb begin
        mul_signed = (bus.md_op == OP_MULT);
        mul_a      = {mul_signed & bus.A_E[31], bus.A_E};
        mul_b      = {mul_signed & bus.B_E[31], bus.B_E};
        product    = mul_a * mul_b;
    end

    // Sign-magnitude divide: truncates toward zero, remainder follows dividend.
    // The 0x80000000 / -1 case falls out naturally as quotient 0x80000000.
    always_comb begin
        div_signed = (bus.md_op == OP_DIV);
        a_neg      = div_signed & bus.A_E[31];
        b_neg      = div_signed & bus.B_E[31];
        a_mag      = a_neg ? (32'd0 - bus.A_E) : bus.A_E;
        b_mag      = b_neg ? (32'd0 - bus.B_E) : bus.B_E;
        div_den    = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / div_den;
        r_mag      = a_mag % div_den;
        quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem        = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Next state: count down while busy, commit on 1->0, otherwise accept start.
    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (busy_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                hi_d   = pend_hi_q;
                lo_d   = pend_lo_q;
            end
        end else if (bus.start) begin
            case (bus.md_op)
                OP_MULT, OP_MULTU: begin
                    pend_hi_d = product[63:32];
                    pend_lo_d = product[31:0];
                    busy_d    = 1'b1;
                    cnt_d     = 4'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    // Divide by zero keeps HI/LO by re-committing their current values.
                    if (bus.B_E == 32'd0) begin
                        pend_hi_d = hi_q;
                        pend_lo_d = lo_q;
                    end else begin
                        pend_hi_d = rem;
                        pend_lo_d = quot;
                    end
                    busy_d = 1'b1;
                    cnt_d  = 4'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = bus.A_E;
                OP_MTLO: lo_d = bus.A_E;
                default: ;
            endcase
        end
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q    <= 1'b0;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // Outputs: stall the D stage while an MD-dependent instruction would race us.
    always_comb begin
        bus.busy     = busy_q;
        bus.HI       = hi_q;
        bus.LO       = lo_q;
        bus.MD_out   = bus.rd_hi ? hi_q : lo_q;
        bus.md_stall = (busy_q | (bus.start & ~bus.md_op[2])) & bus.md_use_D;
    end
endmodule
